// File: rtl/de2_115_ledr_sequencer_if.sv
// Bus bundle for the LEDR sequencer: CPU-facing slave register port plus
// the write-only master port that pushes patterns to the LEDR PIO.
`timescale 1ns/1ps
interface de2_115_ledr_sequencer_if;
    logic [1:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic [31:0] m_address;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    // Handshake: the slave port is zero-wait (a write lands when s_chipselect
    // && !s_write_n at a clock edge, s_readdata follows s_address
    // combinationally). The master port holds m_write/m_writedata stable
    // while m_waitrequest is high; a write completes in the first cycle with
    // m_write && !m_waitrequest.
    modport slave (
        input  s_address, s_chipselect, s_write_n, s_writedata, m_waitrequest,
        output s_readdata, m_address, m_write, m_writedata
    );

    modport master (
        output s_address, s_chipselect, s_write_n, s_writedata, m_waitrequest,
        input  s_readdata, m_address, m_write, m_writedata
    );
endinterface

// File: rtl/de2_115_ledr_sequencer.sv
// LEDR pattern sequencer: CPU-programmed seed/mode/period, steps the pattern
// on each period tick and writes it to the LEDR PIO through an Avalon master.
`timescale 1ns/1ps
module de2_115_ledr_sequencer #(
    parameter int unsigned LED_W          = 18,
    parameter logic [31:0] PIO_ADDR       = 32'h0,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd50_000_000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    de2_115_ledr_sequencer_if.slave        bus,
    output logic                           dbg_state_o
);
    typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_t;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTATE = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic [LED_W-1:0] seed_q, seed_d;
    logic [LED_W-1:0] cur_q, cur_d;
    logic [31:0]      period_q, period_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             dir_q, dir_d;          // 0 = moving left, 1 = moving right
    logic             pending_q, pending_d;

    state_t           state_q;
    logic             m_write_q;
    logic [LED_W-1:0] m_wdata_q;

    logic             wr, wr_ctrl, wr_seed, wr_period;
    logic             tick, en_rise, mode_chg, load;
    logic [31:0]      period_eff;
    logic [LED_W-1:0] step_cur;
    logic             step_phase, step_dir;

    assign wr         = bus.s_chipselect && !bus.s_write_n;
    assign wr_ctrl    = wr && (bus.s_address == 2'd0);
    assign wr_seed    = wr && (bus.s_address == 2'd1);
    assign wr_period  = wr && (bus.s_address == 2'd2);
    assign period_eff = (period_q == 32'd0) ? 32'd1 : period_q;
    assign tick       = en_q && (cnt_q == period_eff - 32'd1);
    assign en_rise    = wr_ctrl && bus.s_writedata[0] && !en_q;
    assign mode_chg   = wr_ctrl && (bus.s_writedata[2:1] != mode_q);
    assign load       = (state_q == ST_IDLE) && pending_q;

    always_comb begin
        step_cur   = cur_q;
        step_phase = phase_q;
        step_dir   = dir_q;
        case (mode_q)
            MODE_STATIC: step_cur = seed_q;
            MODE_BLINK: begin
                step_phase = ~phase_q;
                step_cur   = step_phase ? '0 : seed_q;
            end
            MODE_ROTATE: step_cur = {cur_q[LED_W-2:0], cur_q[LED_W-1]};
            MODE_BOUNCE: begin
                if (!dir_q) begin
                    step_cur = cur_q << 1;
                    if (step_cur[LED_W-1]) step_dir = 1'b1;
                end else begin
                    step_cur = cur_q >> 1;
                    if (step_cur[0]) step_dir = 1'b0;
                end
            end
            default: step_cur = cur_q;
        endcase
    end

    always_comb begin
        en_d     = wr_ctrl ? bus.s_writedata[0] : en_q;
        mode_d   = wr_ctrl ? bus.s_writedata[2:1] : mode_q;
        seed_d   = wr_seed ? bus.s_writedata[LED_W-1:0] : seed_q;
        period_d = wr_period ? bus.s_writedata : period_q;
        cnt_d    = (!en_q || tick || en_rise || mode_chg) ? 32'd0 : cnt_q + 32'd1;
        phase_d  = phase_q;
        dir_d    = dir_q;
        cur_d    = cur_q;
        if (mode_chg) begin
            phase_d = 1'b0;
            dir_d   = 1'b0;
        end else if (tick) begin
            phase_d = step_phase;
            dir_d   = step_dir;
            cur_d   = step_cur;
        end
        // A seed write overrides whatever the tick computed this cycle.
        if (wr_seed) cur_d = bus.s_writedata[LED_W-1:0];
        if (wr_seed || tick || en_rise) pending_d = 1'b1;
        else if (load)                   pending_d = 1'b0;
        else                             pending_d = pending_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q      <= 1'b0;
            mode_q    <= MODE_STATIC;
            seed_q    <= '0;
            cur_q     <= '0;
            period_q  <= DEFAULT_PERIOD;
            cnt_q     <= 32'd0;
            phase_q   <= 1'b0;
            dir_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            en_q      <= en_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            cur_q     <= cur_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            m_write_q <= 1'b0;
            m_wdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pending_q) begin
                        m_wdata_q <= cur_q;
                        m_write_q <= 1'b1;
                        state_q   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!bus.m_waitrequest) begin
                        m_write_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.s_readdata = '0;
        case (bus.s_address)
            2'd0: bus.s_readdata = {29'd0, mode_q, en_q};
            2'd1: bus.s_readdata[LED_W-1:0] = seed_q;
            2'd2: bus.s_readdata = period_q;
            2'd3: begin
                bus.s_readdata[LED_W-1:0] = cur_q;
                bus.s_readdata[31]        = (state_q == ST_WRITE);
            end
        endcase
    end

    assign bus.m_address   = PIO_ADDR;
    assign bus.m_write     = m_write_q;
    assign bus.m_writedata = 32'(m_wdata_q);
    assign dbg_state_o     = (state_q == ST_WRITE);
endmodule

// File: doc/de2_115_ledr_sequencer.md
# de2_115_ledr_sequencer

Avalon-MM LED pattern sequencer for the 18-bit red LED PIO (LEDR) on the DE2-115 SOPC. The CPU configures a seed pattern, an animation mode and a step period through a small slave register file. The block autonomously steps the pattern on every period tick and pushes each new value to the LEDR PIO data register through an Avalon-MM write master with waitrequest handshake.

## Interface
Parameters:
- LED_W, 18, LED bank width
- PIO_ADDR, 32'h0, byte address of LEDR PIO data register (offset 0)
- DEFAULT_PERIOD, 50_000_000, reset value of PERIOD (1 Hz at 50 MHz)

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- s_address  in  2  slave word address
- s_chipselect  in  1  slave select
- s_write_n  in  1  slave write strobe, active-low
- s_writedata  in  32  slave write data
- s_readdata  out  32  slave read data, combinational from s_address, zero-wait
- m_address  out  32  master address, constant PIO_ADDR
- m_write  out  1  master write request
- m_writedata  out  32  {14'b0, pattern[17:0]}
- m_waitrequest  in  1  master stall from fabric

## Operation
- Registers (write when s_chipselect && !s_write_n):
  - 0 CTRL: bit0 EN; bits2:1 MODE (0 static, 1 blink, 2 rotate-left, 3 bounce); other bits read 0.
  - 1 SEED[17:0]: write also loads cur <= seed and sets pending.
  - 2 PERIOD[31:0]: step length in clk cycles; 0 treated as 1.
  - 3 STATUS (read-only): bit31 BUSY (FSM in WRITE), bits17:0 cur; writes ignored.
- Reset: ctrl=0, seed=0, cur=0, period=DEFAULT_PERIOD, cnt=0, phase=0, dir=left, pending=0, m_write=0, m_writedata=0, FSM=IDLE. No write issued after reset.
- Tick counter cnt: runs only when EN=1. Tick asserted in a cycle where cnt==max(PERIOD,1)-1; cnt then wraps to 0. EN=0 holds cnt at 0.
- Step on tick, cur updated and pending set:
  - static: cur=seed.
  - blink: phase toggles; cur = new phase ? 0 : seed. First tick blanks.
  - rotate: cur={cur[16:0],cur[17]}.
  - bounce: dir=left: cur<<1; when result has bit17 set, dir<=right. dir=right: cur>>1; when result has bit0 set, dir<=left. If cur==0, stays 0.
- CTRL write changing MODE: phase<=0, dir<=left, cnt<=0, cur unchanged.
- EN 0->1: cnt<=0, pending set (immediate write of cur). EN 1->0: no new ticks; any in-flight write and existing pending write complete.
- Master FSM:
  - IDLE: if pending, load m_writedata={14'b0,cur}, m_write<=1, pending<=0, go WRITE.
  - WRITE: hold m_write and m_writedata stable while m_waitrequest=1; on m_waitrequest=0, m_write<=0, go IDLE.
- Coalescing: pending is a single flag. Any number of ticks or SEED writes during WRITE yield exactly one follow-up write carrying latest cur.
- Simultaneous SEED write and tick: SEED write wins (cur=new seed); cnt still wraps.

## Timing
- Slave register writes visible on s_readdata the next cycle.
- Tick cycle T: cur and pending update at end of T. With FSM idle, m_write is high from cycle T+2.
- Write completes in the first cycle m_write && !m_waitrequest. m_write is low the following cycle. Minimum back-to-back spacing is 1 idle cycle.
- With PERIOD=P and no stall, consecutive writes are exactly P cycles apart.
- Reset asserted mid-write: m_write drops immediately (async). After release, FSM=IDLE and no write issued.

## Test plan
- Reset: all regs read back defaults (PERIOD=50_000_000, STATUS=0), m_write=0 for 100 cycles after release.
- SEED=0x2AAAA, MODE static, EN=1, PERIOD=8, no stall: first write 0x2AAAA 2 cycles after the CTRL write. Thereafter identical writes every 8 cycles.
- MODE rotate, SEED=0x00001, PERIOD=4: write sequence 0x00001, 0x00002, … 0x20000, 0x00001. Interval 4 cycles.
- MODE bounce, SEED=0x00001, PERIOD=2: writes climb to 0x20000, then 0x10000 … 0x00001, then 0x00002. MODE blink, SEED=0x3FFFF: alternating 0x00000/0x3FFFF.
- PERIOD=2, rotate, hold m_waitrequest=1 for 10 cycles: m_writedata stable throughout. Exactly one follow-up write equals STATUS[17:0] at completion. BUSY=1 during stall.
- Assert reset_n=0 during a stalled write: m_write=0 same cycle. After release, no write until EN set.
